// File: rtl/mem_arbiter_pkg.sv
// Shared memory-interface types for the arbiter slice: command encoding,
// tag/block/address widths and the per-tag owner record.
package mem_arbiter_pkg;

  localparam int unsigned NUM_MEM_TAGS = 15;

  typedef logic [31:0] ADDR;
  typedef logic [63:0] MEM_BLOCK;
  typedef logic [3:0]  MEM_TAG;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef enum logic {
    OWNER_ICACHE = 1'b0,
    OWNER_DCACHE = 1'b1
  } MEM_OWNER;

  typedef struct packed {
    logic     valid;
    MEM_OWNER owner;
  } MEM_OWNER_ENTRY;

endpackage

// File: rtl/mem_tag_owner_table.sv
// Records which requestor owns each in-flight memory tag; looks up and
// retires the owner of a returning tag and keeps a count of live entries.
module mem_tag_owner_table
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_TAGS = NUM_MEM_TAGS
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          alloc_en,
  input  MEM_TAG                        alloc_tag,
  input  MEM_OWNER                      alloc_owner,
  input  MEM_TAG                        lookup_tag,
  output logic                          lookup_valid,
  output MEM_OWNER                      lookup_owner,
  output logic [$clog2(NUM_TAGS+1)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(NUM_TAGS + 1);

  MEM_OWNER_ENTRY             entries      [NUM_TAGS];
  MEM_OWNER_ENTRY             entries_next [NUM_TAGS];
  logic           [CNT_W-1:0] count_next;

  // Retire before allocate so a tag reused in its own return cycle ends up
  // owned by the new requestor; the count is taken from the final table.
  always_comb begin
    lookup_valid = 1'b0;
    lookup_owner = OWNER_ICACHE;
    count_next   = '0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      entries_next[i] = entries[i];
      if (lookup_tag == MEM_TAG'(i + 1)) begin
        lookup_valid          = entries[i].valid;
        lookup_owner          = entries[i].owner;
        entries_next[i].valid = 1'b0;
      end
      if (alloc_en && (alloc_tag == MEM_TAG'(i + 1))) begin
        entries_next[i].valid = 1'b1;
        entries_next[i].owner = alloc_owner;
      end
      count_next = count_next + CNT_W'(entries_next[i].valid);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
        entries[i] <= '0;
      end
      count <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
        entries[i] <= entries_next[i];
      end
      count <= count_next;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between icache reads and dcache loads/stores,
// with a starvation guard for the icache and per-tag routing of returned data.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_TAGS     = NUM_MEM_TAGS,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          icache_req_valid,
  input  ADDR                           icache_req_addr,
  output logic                          icache_req_accepted,
  input  MEM_COMMAND                    dcache_req_command,
  input  ADDR                           dcache_req_addr,
  input  MEM_BLOCK                      dcache_req_data,
  output logic                          dcache_req_accepted,
  output MEM_TAG                        current_req_tag,
  output MEM_COMMAND                    proc2mem_command,
  output ADDR                           proc2mem_addr,
  output MEM_BLOCK                      proc2mem_data,
  input  MEM_TAG                        mem2proc_transaction_tag,
  input  MEM_BLOCK                      mem2proc_data,
  input  MEM_TAG                        mem2proc_data_tag,
  output MEM_TAG                        icache_data_tag,
  output MEM_TAG                        dcache_data_tag,
  output MEM_BLOCK                      mem_data,
  output logic [$clog2(NUM_TAGS+1)-1:0] outstanding_count,
  output logic                          tag_error
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          dcache_wants;
  logic          grant_icache;
  logic          grant_dcache;
  logic          mem_took;
  logic          alloc_en;
  MEM_OWNER      alloc_owner;
  logic          lookup_valid;
  MEM_OWNER      lookup_owner;

  always_comb begin
    dcache_wants = (dcache_req_command != MEM_NONE);
    grant_icache = icache_req_valid &&
                   (!dcache_wants || (starve_cnt == SW'(STARVE_LIMIT)));
    grant_dcache = dcache_wants && !grant_icache;
    mem_took     = (mem2proc_transaction_tag != '0);

    icache_req_accepted = grant_icache && mem_took;
    dcache_req_accepted = grant_dcache && mem_took;
    current_req_tag     = mem2proc_transaction_tag;

    proc2mem_command = MEM_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (grant_icache) begin
      proc2mem_command = MEM_LOAD;
      proc2mem_addr    = icache_req_addr;
    end else if (grant_dcache) begin
      proc2mem_command = dcache_req_command;
      proc2mem_addr    = dcache_req_addr;
      proc2mem_data    = dcache_req_data;
    end

    // Stores never come back with data, so only accepted loads take a tag.
    alloc_en    = (icache_req_accepted || dcache_req_accepted) &&
                  (proc2mem_command == MEM_LOAD);
    alloc_owner = grant_dcache ? OWNER_DCACHE : OWNER_ICACHE;

    icache_data_tag = (lookup_valid && lookup_owner == OWNER_ICACHE) ? mem2proc_data_tag : '0;
    dcache_data_tag = (lookup_valid && lookup_owner == OWNER_DCACHE) ? mem2proc_data_tag : '0;
    mem_data        = mem2proc_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
      tag_error  <= 1'b0;
    end else begin
      if (icache_req_valid && !icache_req_accepted) begin
        if (starve_cnt != SW'(STARVE_LIMIT)) begin
          starve_cnt <= starve_cnt + SW'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
      if ((mem2proc_data_tag != '0) && !lookup_valid) begin
        tag_error <= 1'b1;
      end
    end
  end

  mem_tag_owner_table #(
    .NUM_TAGS (NUM_TAGS)
  ) u_owner_table (
    .clock        (clock),
    .reset        (reset),
    .alloc_en     (alloc_en),
    .alloc_tag    (mem2proc_transaction_tag),
    .alloc_owner  (alloc_owner),
    .lookup_tag   (mem2proc_data_tag),
    .lookup_valid (lookup_valid),
    .lookup_owner (lookup_owner),
    .count        (outstanding_count)
  );

endmodule
